// File: rtl/protocore_pkg.sv
// ============================================================================
// protocore_pkg: shared widths, defaults and the fetch FIFO entry type. Rev 1.0
// ============================================================================
`default_nettype none

package protocore_pkg;

   localparam int ADDR_W          = 8;
   localparam int INSTR_W_DEFAULT = 16;
   localparam int FETCH_DEPTH     = 2;

   typedef struct packed {
      logic [INSTR_W_DEFAULT-1:0] instr;
      logic [ADDR_W-1:0]          pc;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if: PC, instruction-memory, decode and redirect signals. Rev 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if
   import protocore_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEFAULT
) ();

   logic [ADDR_W-1:0]  pc_addr;
   logic               pc_en;
   logic               pc_overwrite;
   logic [ADDR_W-1:0]  pc_overwrite_data;
   logic               imem_en;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               dec_valid;
   logic               dec_ready;
   logic [INSTR_W-1:0] dec_instr;
   logic [ADDR_W-1:0]  dec_pc;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;

   modport master (
      input  pc_addr, imem_rdata, dec_ready, redirect_valid, redirect_addr,
      output pc_en, pc_overwrite, pc_overwrite_data, imem_en, imem_addr,
             dec_valid, dec_instr, dec_pc
   );

   modport slave (
      output pc_addr, imem_rdata, dec_ready, redirect_valid, redirect_addr,
      input  pc_en, pc_overwrite, pc_overwrite_data, imem_en, imem_addr,
             dec_valid, dec_instr, dec_pc
   );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo: DEPTH-entry synchronous FIFO; flush wins over push. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
   import protocore_pkg::*;
#(
   parameter int  DEPTH = FETCH_DEPTH,
   parameter type T     = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  T                       data_i,
   output T                       head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   T                 mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + (PTR_W+1)'(push_i) - (PTR_W+1)'(pop_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is left unreset; it is only observed through a non-zero count.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit: credit-based instruction fetch feeding decode. FETCH_STALL_CNT_EN
// adds the stall_cnt port. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit
   import protocore_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEFAULT,
   parameter int DEPTH   = FETCH_DEPTH
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
`ifdef FETCH_STALL_CNT_EN
   ,
   output logic [15:0]  stall_cnt
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } entry_t;

   logic              inflight_q, inflight_d;
   logic              drop_q, drop_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    credit;
   logic              resp, empty, pop, fifo_push, fifo_pop, issue, valid;
   entry_t            resp_entry, head, dec_entry;

   always_comb begin
      resp             = inflight_q & ~drop_q;
      empty            = (count == '0);
      resp_entry.instr = bus.imem_rdata;
      resp_entry.pc    = addr_q;
      // An empty FIFO forwards the returning word straight to decode.
      dec_entry        = empty ? resp_entry : head;
      valid            = ~rst & (~empty | resp);
      pop              = valid & bus.dec_ready & ~bus.redirect_valid;
      fifo_pop         = pop & ~empty;
      fifo_push        = resp & ~(pop & empty);

      credit = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
      issue  = ~rst & ~bus.redirect_valid & (credit < (CNT_W+1)'(DEPTH));

      inflight_d = issue;
      drop_d     = bus.redirect_valid & inflight_q;
      addr_d     = issue ? bus.pc_addr : addr_q;

      bus.pc_en             = issue;
      bus.imem_en           = issue;
      bus.imem_addr         = rst ? '0 : bus.pc_addr;
      bus.pc_overwrite      = ~rst & bus.redirect_valid;
      bus.pc_overwrite_data = (~rst & bus.redirect_valid) ? bus.redirect_addr : '0;
      bus.dec_valid         = valid;
      bus.dec_instr         = valid ? dec_entry.instr : '0;
      bus.dec_pc            = valid ? dec_entry.pc    : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         addr_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         addr_q     <= addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .flush_i (bus.redirect_valid),
      .data_i  (resp_entry),
      .head_o  (head),
      .count_o (count)
   );

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.dec_ready && !valid && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit: directed vector table, corner sequences and random traffic
// checked against a transaction-level model of fetch_unit. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
   import protocore_pkg::*;

   localparam int DEPTH = 2;
   localparam int IW    = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_unit_if #(.INSTR_W(IW)) bus ();
`ifdef FETCH_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   fetch_unit #(.INSTR_W(IW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Model: items issued since the last redirect and not yet accepted, the
   // address decode must see next, and the expected stall count.
   int         outstanding;
   logic [7:0] exp_pc;
   int         stall_m;
   logic [7:0]  nxt_pc;
   logic [15:0] nxt_rdata;

   typedef struct {
      logic       rdy;
      logic       rv;
      logic [7:0] ra;
      logic       ev;
      logic [7:0] epc;
      logic       een;
   } vec_t;
   vec_t tbl [18];

   function automatic logic [15:0] word(input logic [7:0] a);
      return {8'hA0, a};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      outstanding = 0;
      exp_pc      = 8'h00;
      stall_m     = 0;
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_dec_valid"}, 32'(bus.dec_valid), 32'd0);
      chk({tag, "_pc_en"},     32'(bus.pc_en), 32'd0);
      chk({tag, "_imem_en"},   32'(bus.imem_en), 32'd0);
      chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, "_ovr"},       32'(bus.pc_overwrite), 32'd0);
      chk({tag, "_ovr_data"},  32'(bus.pc_overwrite_data), 32'd0);
      chk({tag, "_dec_pc"},    32'(bus.dec_pc), 32'd0);
      chk({tag, "_dec_instr"}, 32'(bus.dec_instr), 32'd0);
`ifdef FETCH_STALL_CNT_EN
      chk({tag, "_stall"},     32'(stall_cnt), 32'd0);
`endif
   endtask

   task automatic model_check();
      logic ev, pop, een;
      ev  = (outstanding > 0);
      pop = ev && bus.dec_ready;
      een = !bus.redirect_valid && ((outstanding - int'(pop)) < DEPTH);
      chk("m_dec_valid", 32'(bus.dec_valid), 32'(ev));
      chk("m_pc_en",     32'(bus.pc_en), 32'(een));
      chk("m_imem_en",   32'(bus.imem_en), 32'(een));
      chk("m_imem_addr", 32'(bus.imem_addr), 32'(bus.pc_addr));
      chk("m_ovr",       32'(bus.pc_overwrite), 32'(bus.redirect_valid));
      if (bus.redirect_valid)
         chk("m_ovr_data", 32'(bus.pc_overwrite_data), 32'(bus.redirect_addr));
      if (ev) begin
         chk("m_dec_pc",    32'(bus.dec_pc), 32'(exp_pc));
         chk("m_dec_instr", 32'(bus.dec_instr), 32'(word(exp_pc)));
      end
`ifdef FETCH_STALL_CNT_EN
      chk("m_stall", 32'(stall_cnt), 32'(stall_m));
`endif
      if (bus.dec_ready && !ev && stall_m < 65535) stall_m++;
      if (bus.redirect_valid) begin
         outstanding = 0;
         exp_pc      = bus.redirect_addr;
      end else begin
         if (pop) exp_pc = exp_pc + 8'd1;
         outstanding = outstanding - int'(pop) + int'(een);
      end
   endtask

   // Program counter and synchronous memory of the surrounding pipeline.
   task automatic to_next();
      nxt_pc    = bus.pc_overwrite ? bus.pc_overwrite_data
                : (bus.pc_en ? bus.pc_addr + 8'd1 : bus.pc_addr);
      nxt_rdata = bus.imem_en ? word(bus.imem_addr) : bus.imem_rdata;
      @(posedge clk);
      #1;
      bus.pc_addr    = nxt_pc;
      bus.imem_rdata = nxt_rdata;
   endtask

   task automatic step();
      @(negedge clk);
      model_check();
      to_next();
   endtask

   initial begin
      logic found;

      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 8'h40, 1'b1, 8'h04, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1};
      tbl[12] = '{1'b1, 1'b1, 8'hFE, 1'b1, 8'h42, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
      tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b1};
      tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b1};
      tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
      tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1};

      rst                = 1'b1;
      bus.pc_addr        = 8'h33;
      bus.imem_rdata     = 16'h1234;
      bus.dec_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = 8'h55;
      model_reset();
      #2;
      reset_checks("rst0");

      bus.redirect_valid = 1'b0;
      bus.pc_addr        = 8'h00;
      bus.imem_rdata     = 16'h0000;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming, backpressure, redirect with an in-flight fetch, wrap-around.
      for (int i = 0; i < 18; i++) begin
         bus.dec_ready      = tbl[i].rdy;
         bus.redirect_valid = tbl[i].rv;
         bus.redirect_addr  = tbl[i].ra;
         @(negedge clk);
         chk($sformatf("t%0d_dec_valid", i), 32'(bus.dec_valid), 32'(tbl[i].ev));
         chk($sformatf("t%0d_pc_en", i),     32'(bus.pc_en), 32'(tbl[i].een));
         chk($sformatf("t%0d_imem_en", i),   32'(bus.imem_en), 32'(tbl[i].een));
         chk($sformatf("t%0d_ovr", i),       32'(bus.pc_overwrite), 32'(tbl[i].rv));
         if (tbl[i].rv)
            chk($sformatf("t%0d_ovr_data", i), 32'(bus.pc_overwrite_data), 32'(tbl[i].ra));
         if (tbl[i].ev) begin
            chk($sformatf("t%0d_dec_pc", i),    32'(bus.dec_pc), 32'(tbl[i].epc));
            chk($sformatf("t%0d_dec_instr", i), 32'(bus.dec_instr), 32'(word(tbl[i].epc)));
         end
         model_check();
         to_next();
      end
      bus.redirect_valid = 1'b0;

      // Fill the FIFO, then assert reset between clock edges.
      bus.dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      #2;
      rst = 1'b1;
      #1;
      reset_checks("rst_mid");
      bus.pc_addr    = 8'h00;
      bus.imem_rdata = 16'h0000;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst           = 1'b0;
      bus.dec_ready = 1'b1;
      found         = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (!found && bus.dec_valid) begin
            found = 1'b1;
            chk("rst_restart_pc", 32'(bus.dec_pc), 32'h00);
         end
         model_check();
         to_next();
      end
      chk("rst_restart_seen", 32'(found), 32'd1);

      // Redirects one cycle apart with decode always ready.
      for (int i = 0; i < 9; i++) begin
         bus.redirect_valid = (i == 0 || i == 2 || i == 4);
         bus.redirect_addr  = 8'h80 + 8'(i);
         step();
      end
      bus.redirect_valid = 1'b0;

      for (int i = 0; i < 800; i++) begin
         bus.dec_ready      = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = ($urandom_range(0, 15) == 0);
         bus.redirect_addr  = 8'($urandom);
         step();
      end
      bus.redirect_valid = 1'b0;

      #2;
      rst = 1'b1;
      #1;
      reset_checks("rst_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
